// File: rtl/i2s_rx_fifo.sv
// I2S / left-justified audio receiver oversampled on MCLK, feeding a channel-tagged
// first-word-fall-through FIFO with level, overflow and synchronous flush.
//   state | meaning
//   IDLE  | waiting for an LRC edge; no slot in progress
//   SKIP  | I2S delay bit after the LRC edge
//   SHIFT | capturing sample bits, MSB first
//   WAIT  | sample done, ignoring remaining slot bits until next LRC edge
module i2s_rx_fifo #(
    parameter int SAMPLE_W = 24,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0
) (
    input  logic                      MCLK,
    input  logic                      reset,
    input  logic                      AUD_BCLK,
    input  logic                      AUD_LRC,
    input  logic                      AUD_ADC_DATA,
    input  logic                      writeEn_in,
    input  logic                      readEn_in,
    input  logic                      clear_in,
    output logic [SAMPLE_W-1:0]       aFIFO_out,
    output logic                      chan_out,
    output logic                      emptyOut,
    output logic                      fullOut,
    output logic [$clog2(DEPTH):0]    level_out,
    output logic                      overflow_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SAMPLE_W + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} rx_state_t;

    logic [2:0]          bclk_sync;
    logic [1:0]          lrc_sync;
    logic [1:0]          data_sync;
    logic                bclk_rise;
    logic                lrc;
    logic                data;
    logic                lrc_prev;
    logic                lrc_vld;
    logic                lrc_edge;

    rx_state_t           state;
    logic [CW-1:0]       bit_cnt;
    logic [SAMPLE_W-1:0] shreg;
    logic                chan;
    logic                push_req;

    logic [SAMPLE_W:0]   mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [AW:0]         wr_next;
    logic [AW:0]         rd_next;
    logic                accept;
    logic                do_push;
    logic                do_pop;
    logic [SAMPLE_W:0]   wdata;

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            data_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
            lrc_sync  <= {lrc_sync[0], AUD_LRC};
            data_sync <= {data_sync[0], AUD_ADC_DATA};
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign lrc       = lrc_sync[1];
    assign data      = data_sync[1];

    // The first rise after reset only seeds the LRC history, so a slot already in
    // progress at reset release is never mistaken for a fresh LRC edge.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            lrc_prev <= 1'b0;
            lrc_vld  <= 1'b0;
        end else if (bclk_rise) begin
            lrc_prev <= lrc;
            lrc_vld  <= 1'b1;
        end
    end

    assign lrc_edge = bclk_rise && lrc_vld && (lrc != lrc_prev);

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            chan     <= 1'b0;
            push_req <= 1'b0;
        end else if (clear_in) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (lrc_edge) begin
                chan <= lrc;
                if (MODE == 1) begin
                    shreg   <= {shreg[SAMPLE_W-2:0], data};
                    bit_cnt <= CW'(1);
                    state   <= SHIFT;
                end else begin
                    bit_cnt <= '0;
                    state   <= SKIP;
                end
            end else if (bclk_rise) begin
                case (state)
                    SKIP: begin
                        shreg   <= {shreg[SAMPLE_W-2:0], data};
                        bit_cnt <= CW'(1);
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        shreg <= {shreg[SAMPLE_W-2:0], data};
                        if (bit_cnt == CW'(SAMPLE_W - 1)) begin
                            push_req <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= WAIT;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wdata   = {chan, shreg};
    assign accept  = push_req && writeEn_in && ((CHANNELS == 2) || (chan == 1'b0));
    assign do_pop  = readEn_in && !emptyOut;
    assign do_push = accept && (!fullOut || do_pop);
    assign wr_next = wr_ptr + (AW+1)'(do_push);
    assign rd_next = rd_ptr + (AW+1)'(do_pop);

    always_ff @(posedge MCLK) begin
        if (do_push && !clear_in)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_out    <= '0;
            emptyOut     <= 1'b1;
            fullOut      <= 1'b0;
            overflow_out <= 1'b0;
        end else if (clear_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_out    <= '0;
            emptyOut     <= 1'b1;
            fullOut      <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            level_out <= wr_next - rd_next;
            emptyOut  <= (wr_next == rd_next);
            fullOut   <= (wr_next[AW] != rd_next[AW]) &&
                         (wr_next[AW-1:0] == rd_next[AW-1:0]);
            if (accept && fullOut && !do_pop)
                overflow_out <= 1'b1;
        end
    end

    // Head register gives fall-through: a push into an empty FIFO appears at once,
    // and a pop of the last word keeps the old value visible.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            {chan_out, aFIFO_out} <= '0;
        end else if (!clear_in) begin
            if (do_push && emptyOut) begin
                {chan_out, aFIFO_out} <= wdata;
            end else if (do_pop) begin
                if (level_out == (AW+1)'(1)) begin
                    if (do_push)
                        {chan_out, aFIFO_out} <= wdata;
                end else begin
                    {chan_out, aFIFO_out} <= mem[rd_next[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Directed bench: I2S (MODE0, 2 ch) and left-justified (MODE1, 1 ch) receivers
// share one codec stream; BCLK = MCLK/8, 32-bit slots.
module tb_i2s_rx_fifo;

    logic        mclk;
    logic        rst_n;
    logic        bclk;
    logic        lrc;
    logic        sdata;
    logic        wr_en;
    logic        rd_a;
    logic        rd_b;
    logic        clr;

    logic [23:0] data_a, data_b;
    logic        chan_a, chan_b;
    logic        empty_a, empty_b;
    logic        full_a, full_b;
    logic [4:0]  level_a, level_b;
    logic        ovf_a, ovf_b;

    int n_checks = 0;
    int n_errors = 0;

    i2s_rx_fifo #(.SAMPLE_W(24), .DEPTH(16), .CHANNELS(2), .MODE(0)) u_dut_a (
        .MCLK(mclk), .reset(rst_n), .AUD_BCLK(bclk), .AUD_LRC(lrc), .AUD_ADC_DATA(sdata),
        .writeEn_in(wr_en), .readEn_in(rd_a), .clear_in(clr),
        .aFIFO_out(data_a), .chan_out(chan_a), .emptyOut(empty_a), .fullOut(full_a),
        .level_out(level_a), .overflow_out(ovf_a)
    );

    i2s_rx_fifo #(.SAMPLE_W(24), .DEPTH(16), .CHANNELS(1), .MODE(1)) u_dut_b (
        .MCLK(mclk), .reset(rst_n), .AUD_BCLK(bclk), .AUD_LRC(lrc), .AUD_ADC_DATA(sdata),
        .writeEn_in(wr_en), .readEn_in(rd_b), .clear_in(clr),
        .aFIFO_out(data_b), .chan_out(chan_b), .emptyOut(empty_b), .fullOut(full_b),
        .level_out(level_b), .overflow_out(ovf_b)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic slot_bit(input logic [23:0] s, input logic lj, input int i);
        if (lj)
            return (i < 24) ? s[23-i] : 1'b0;
        return (i >= 1 && i <= 24) ? s[24-i] : 1'b0;
    endfunction

    // opt 1: pop dut_b in the push cycle; opt 2: probe dut_b empty latency
    task automatic send_bit(input logic l, input logic d, input int opt);
        bclk  = 1'b0;
        lrc   = l;
        sdata = d;
        repeat (4) @(negedge mclk);
        bclk = 1'b1;
        repeat (3) @(negedge mclk);
        if (opt == 1) rd_b = 1'b1;
        if (opt == 2) check_eq("lat_pre", 32'(empty_b), 32'd1);
        @(negedge mclk);
        rd_b = 1'b0;
        if (opt == 2) check_eq("lat_post", 32'(empty_b), 32'd0);
    endtask

    task automatic send_slot(input logic l, input logic [23:0] s, input logic lj,
                             input int first, input int last, input int opt);
        for (int i = first; i <= last; i++)
            send_bit(l, slot_bit(s, lj, i), (i == (lj ? 23 : 24)) ? opt : 0);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input logic lj, input int opt);
        send_slot(1'b0, l, lj, 0, 31, opt);
        send_slot(1'b1, r, lj, 0, 31, 0);
    endtask

    task automatic pop_a();
        rd_a = 1'b1;
        @(negedge mclk);
        rd_a = 1'b0;
    endtask

    task automatic pop_b();
        rd_b = 1'b1;
        @(negedge mclk);
        rd_b = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge mclk);
        clr = 1'b0;
    endtask

    task automatic check_reset_b(input string tag);
        check_eq({tag, "_data"},  32'(data_b),  32'd0);
        check_eq({tag, "_chan"},  32'(chan_b),  32'd0);
        check_eq({tag, "_empty"}, 32'(empty_b), 32'd1);
        check_eq({tag, "_full"},  32'(full_b),  32'd0);
        check_eq({tag, "_level"}, 32'(level_b), 32'd0);
        check_eq({tag, "_ovf"},   32'(ovf_b),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bclk  = 1'b0;
        lrc   = 1'b0;
        sdata = 1'b0;
        wr_en = 1'b1;
        rd_a  = 1'b0;
        rd_b  = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge mclk);
        check_eq("rst_a_data",  32'(data_a),  32'd0);
        check_eq("rst_a_chan",  32'(chan_a),  32'd0);
        check_eq("rst_a_empty", 32'(empty_a), 32'd1);
        check_eq("rst_a_full",  32'(full_a),  32'd0);
        check_eq("rst_a_level", 32'(level_a), 32'd0);
        check_eq("rst_a_ovf",   32'(ovf_a),   32'd0);
        rst_n = 1'b1;
        @(negedge mclk);

        // I2S stereo, first (right) slot after reset must be dropped
        send_slot(1'b1, 24'hFEDCBA, 1'b0, 0, 31, 0);
        check_eq("t1_first_slot_level", 32'(level_a), 32'd0);
        send_frame(24'hABCDEF, 24'h123456, 1'b0, 0);
        check_eq("t1_level", 32'(level_a), 32'd2);
        check_eq("t1_head0", 32'(data_a), 32'hABCDEF);
        check_eq("t1_chan0", 32'(chan_a), 32'd0);
        pop_a();
        check_eq("t1_head1", 32'(data_a), 32'h123456);
        check_eq("t1_chan1", 32'(chan_a), 32'd1);
        pop_a();
        check_eq("t1_empty", 32'(empty_a), 32'd1);
        check_eq("t1_hold",  32'(data_a), 32'h123456);
        pop_a();
        check_eq("t1_pop_empty_level", 32'(level_a), 32'd0);
        check_eq("t1_pop_empty_hold",  32'(data_a), 32'h123456);
        pulse_clear();

        // Left-justified stream: MODE1 aligned, MODE0 loses the MSB
        send_slot(1'b1, 24'h000000, 1'b1, 0, 31, 0);
        send_frame(24'h800001, 24'h000000, 1'b1, 0);
        check_eq("t3_lj_level", 32'(level_b), 32'd1);
        check_eq("t3_lj_data",  32'(data_b),  32'h800001);
        check_eq("t3_i2s_data", 32'(data_a),  32'h000002);
        check_eq("t3_i2s_chan", 32'(chan_a),  32'd0);
        check_eq("t3_i2s_level", 32'(level_a), 32'd2);
        pulse_clear();

        // Mono fill to full, then one overflow
        for (int i = 0; i < 16; i++)
            send_frame(24'h100000 + 24'(i), 24'hFFFFFF, 1'b1, 0);
        check_eq("t2_level16", 32'(level_b), 32'd16);
        check_eq("t2_full",    32'(full_b),  32'd1);
        check_eq("t2_ovf0",    32'(ovf_b),   32'd0);
        send_frame(24'h1000FF, 24'hFFFFFF, 1'b1, 0);
        check_eq("t2_level_after_drop", 32'(level_b), 32'd16);
        check_eq("t2_ovf1", 32'(ovf_b),  32'd1);
        check_eq("t2_head", 32'(data_b), 32'h100000);
        pulse_clear();
        check_eq("clr_level", 32'(level_b), 32'd0);
        check_eq("clr_empty", 32'(empty_b), 32'd1);
        check_eq("clr_full",  32'(full_b),  32'd0);
        check_eq("clr_ovf",   32'(ovf_b),   32'd0);
        check_eq("clr_hold",  32'(data_b),  32'h100000);

        // Full FIFO with push and pop in the same cycle, across pointer wrap
        for (int k = 0; k < 16; k++)
            send_frame(24'h200000 + 24'(k), 24'h0, 1'b1, 0);
        for (int k = 16; k < 40; k++) begin
            send_frame(24'h200000 + 24'(k), 24'h0, 1'b1, 1);
            check_eq("t6_level", 32'(level_b), 32'd16);
            check_eq("t6_head",  32'(data_b),  32'h200000 + 32'(k - 15));
        end
        check_eq("t6_ovf", 32'(ovf_b), 32'd0);
        for (int j = 24; j < 40; j++) begin
            check_eq("t6_drain", 32'(data_b), 32'h200000 + 32'(j));
            pop_b();
        end
        check_eq("t6_empty", 32'(empty_b), 32'd1);
        pulse_clear();

        // Slot cut short by an early LRC edge
        send_slot(1'b0, 24'h0A0A0A, 1'b1, 0, 9, 0);
        send_slot(1'b1, 24'hFFFFFF, 1'b1, 0, 31, 0);
        check_eq("t4_partial_level", 32'(level_b), 32'd0);
        send_frame(24'h5A5A5A, 24'h0, 1'b1, 2);
        check_eq("t4_level", 32'(level_b), 32'd1);
        check_eq("t4_data",  32'(data_b),  32'h5A5A5A);
        pulse_clear();

        // Clear mid-slot with words queued
        for (int i = 0; i < 5; i++)
            send_frame(24'h300000 + 24'(i), 24'h0, 1'b1, 0);
        check_eq("t5_level5", 32'(level_b), 32'd5);
        send_slot(1'b0, 24'h0F0F0F, 1'b1, 0, 9, 0);
        pulse_clear();
        check_eq("t5_clr_level", 32'(level_b), 32'd0);
        check_eq("t5_clr_empty", 32'(empty_b), 32'd1);
        check_eq("t5_clr_ovf",   32'(ovf_b),   32'd0);
        check_eq("t5_clr_hold",  32'(data_b),  32'h300000);
        send_slot(1'b0, 24'h0F0F0F, 1'b1, 10, 31, 0);
        send_slot(1'b1, 24'h0, 1'b1, 0, 31, 0);
        check_eq("t5_inflight_dropped", 32'(level_b), 32'd0);
        send_frame(24'h777777, 24'h0, 1'b1, 0);
        check_eq("t5_after_clr_level", 32'(level_b), 32'd1);
        check_eq("t5_after_clr_data",  32'(data_b),  32'h777777);

        // Reset mid-slot
        send_slot(1'b0, 24'h0F0F0F, 1'b1, 0, 9, 0);
        rst_n = 1'b0;
        @(negedge mclk);
        check_reset_b("t5_rst");
        rst_n = 1'b1;
        @(negedge mclk);
        send_slot(1'b0, 24'h0F0F0F, 1'b1, 10, 31, 0);
        send_slot(1'b1, 24'h0, 1'b1, 0, 31, 0);
        check_eq("t5_rst_partial", 32'(level_b), 32'd0);
        send_frame(24'h314159, 24'h0, 1'b1, 2);
        check_eq("t5_rst_level", 32'(level_b), 32'd1);
        check_eq("t5_rst_data",  32'(data_b),  32'h314159);
        check_eq("t5_rst_chan",  32'(chan_b),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
